// File: rtl/shake_squeeze.sv
// -----------------------------------------------------------------------------
// shake_squeeze
//
// Squeeze-phase engine for the SHAKE / Keccak sponge. Takes a fully absorbed,
// already-permuted 1600-bit state and streams the requested number of W-bit
// words out of the rate portion. When the rate portion is used up and more
// words are still owed, it hands the state to the shared Keccak-f[1600] core
// through a start/done handshake. Emission resumes from word 0 of the
// permuted result.
//
// Parameters
//   RATE : rate in bits (1088 for SHAKE256, 1344 for SHAKE128); multiple of W
//   W    : output word width, one of 8/16/32/64
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   st_valid     absorbed state offered
//   st_ready     block idle, can accept a state
//   st_in        absorbed, permuted state (lane order, bit 0 = lane 0 bit 0)
//   out_words    number of W-bit words requested, sampled on the st handshake
//   stop         (SHAKE_SQ_STREAM_EN only) abort an unbounded stream
//   perm_start   one-cycle permutation request
//   perm_state   state to permute, valid while waiting for perm_done
//   perm_done    one-cycle permutation completion
//   perm_result  permuted state, valid with perm_done
//   dout         output word
//   dout_valid   dout valid
//   dout_ready   consumer accepts dout
//   dout_last    final requested word, qualified by dout_valid
//   busy         high whenever the engine is not idle
//
// Configuration
//   SHAKE_SQ_STREAM_EN : when defined, adds the `stop` input and makes
//   out_words=0 an unbounded XOF stream (dout_last never asserted). When
//   undefined, out_words=0 is a zero-length request that produces no output.
// -----------------------------------------------------------------------------
module shake_squeeze #(
  parameter int RATE = 1088,
  parameter int W    = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  output logic          st_ready,
  input  logic [1599:0] st_in,
  input  logic [15:0]   out_words,
`ifdef SHAKE_SQ_STREAM_EN
  input  logic          stop,
`endif
  output logic          perm_start,
  output logic [1599:0] perm_state,
  input  logic          perm_done,
  input  logic [1599:0] perm_result,
  output logic [W-1:0]  dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          busy
);

  // Number of W-bit words in the rate portion of one state.
  localparam int WORDS = RATE / W;
  localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

  // Reject configurations the word slicing cannot serve.
  if ((W != 8) && (W != 16) && (W != 32) && (W != 64)) begin : g_bad_w
    $error("shake_squeeze: W must be 8, 16, 32 or 64");
  end
  if ((RATE % W != 0) || (RATE > 1600) || (RATE < W)) begin : g_bad_rate
    $error("shake_squeeze: RATE must be a multiple of W and at most 1600");
  end

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    PERM_REQ,
    PERM_WAIT
  } state_t;

  state_t          state;
  logic [1599:0]   s_reg;      // current sponge state S
  logic [KW-1:0]   k;          // index of the word currently on dout
  logic [15:0]     remaining;  // words still owed, including the one on dout
  logic [KW-1:0]   k_next;

  assign k_next = k + 1'b1;

  // The state register is what the permutation core reads while we wait.
  assign perm_state = s_reg;

`ifdef SHAKE_SQ_STREAM_EN
  logic unbounded;  // out_words was 0: stream until stop
  logic stop_hit;
  // stop only matters for an unbounded stream.
  assign stop_hit = stop & unbounded;
`else
  logic unbounded;
  logic stop_hit;
  assign unbounded = 1'b0;
  assign stop_hit  = 1'b0;
`endif

  // A request leaves IDLE when it owes at least one word, or when it is an
  // unbounded stream in the streaming build.
  logic start_emit;
`ifdef SHAKE_SQ_STREAM_EN
  assign start_emit = 1'b1;
`else
  assign start_emit = (out_words != 16'd0);
`endif

  // All outputs are registered: every transition below also sets the values
  // the outputs must show in the following cycle, so dout/dout_last only move
  // on a handshake and stay put while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state is written with non-blocking assignments only,
      // so every register here sees the pre-edge value of every other one.
      state      <= IDLE;
      // NOTE: the wide state register is reset on purpose: it drives
      // perm_state directly, which must read zero out of reset.
      s_reg      <= '0;
      k          <= '0;
      remaining  <= '0;
      st_ready   <= 1'b1;
      busy       <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      perm_start <= 1'b0;
`ifdef SHAKE_SQ_STREAM_EN
      unbounded  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (st_valid) begin
            s_reg     <= st_in;
            k         <= '0;
            remaining <= out_words;
`ifdef SHAKE_SQ_STREAM_EN
            unbounded <= (out_words == 16'd0);
`endif
            if (start_emit) begin
              state      <= EMIT;
              st_ready   <= 1'b0;
              busy       <= 1'b1;
              dout       <= st_in[W-1:0];
              dout_valid <= 1'b1;
              dout_last  <= (out_words == 16'd1);
            end
          end
        end

        EMIT: begin
          if (stop_hit) begin
            // Abort drops the word currently on dout.
            state      <= IDLE;
            st_ready   <= 1'b1;
            busy       <= 1'b0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
          end else if (dout_ready) begin
            if (!unbounded && (remaining == 16'd1)) begin
              // Final requested word accepted.
              state      <= IDLE;
              remaining  <= '0;
              st_ready   <= 1'b1;
              busy       <= 1'b0;
              dout_valid <= 1'b0;
              dout_last  <= 1'b0;
            end else begin
              if (!unbounded) begin
                remaining <= remaining - 16'd1;
              end
              if (k == K_LAST) begin
                // Rate exhausted with words still owed: capacity bits are
                // never emitted, so ask for a fresh permutation instead.
                state      <= PERM_REQ;
                perm_start <= 1'b1;
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
              end else begin
                k         <= k_next;
                dout      <= s_reg[int'(k_next)*W +: W];
                // The next word is last when exactly two were owed before
                // this handshake.
                dout_last <= !unbounded && (remaining == 16'd2);
              end
            end
          end
        end

        PERM_REQ: begin
          // perm_start was raised on entry; it lasts exactly this one cycle.
          perm_start <= 1'b0;
          state      <= PERM_WAIT;
        end

        PERM_WAIT: begin
          if (stop_hit) begin
            // The core is not told; its eventual perm_done lands in IDLE
            // and is ignored there.
            state    <= IDLE;
            st_ready <= 1'b1;
            busy     <= 1'b0;
          end else if (perm_done) begin
            s_reg      <= perm_result;
            k          <= '0;
            state      <= EMIT;
            dout       <= perm_result[W-1:0];
            dout_valid <= 1'b1;
            dout_last  <= !unbounded && (remaining == 16'd1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
